psm_phase_gen: RTL and testbench

PSM_PHASE_GEN -- requirements
Module: psm_phase_gen

---
 rtl/psm_phase_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_psm_phase_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psm_phase_gen.sv
// ---------------------------------------------------------------------------
// psm_phase_gen
// Phase-shifted gate pattern generator for N_LEGS half-bridge legs.
// A shared up-counter (0..P) sets the period. Each leg compares its phase-offset
// position against half the period to form a reference. That reference is
// registered once and then passed through a deadtime inserter that drives the
// complementary high/low gate pair.
// New period/phase/deadtime values are double-buffered. iLOAD fills a shadow
// copy, and the shadow becomes active only on a counter wrap.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   iEN        in   run request (level)
//   iPERIOD    in   counter top value P (period = P+1 cycles)
//   iPHASE     in   per-leg phase offsets, leg i at [i*BITS_DATA +: BITS_DATA]
//   iDEADTIME  in   deadtime D in cycles
//   iLOAD      in   capture iPERIOD/iPHASE/iDEADTIME into the shadow copy
//   oLOAD_ACK  out  pulse in the cycle shadow values become active
//   oSYNC      out  pulse in the first cycle (cnt==0) of each running period
//   oRUN       out  high while START, RUN or STOP
//   oPSM       out  gate pairs: bit 2i high side, bit 2i+1 low side of leg i
// ---------------------------------------------------------------------------
module psm_phase_gen #(
  parameter int BITS_DATA = 16,
  parameter int N_LEGS    = 4,
  parameter int DT_BITS   = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        iEN,
  input  logic [BITS_DATA-1:0]        iPERIOD,
  input  logic [N_LEGS*BITS_DATA-1:0] iPHASE,
  input  logic [DT_BITS-1:0]          iDEADTIME,
  input  logic                        iLOAD,
  output logic                        oLOAD_ACK,
  output logic                        oSYNC,
  output logic                        oRUN,
  output logic [2*N_LEGS-1:0]         oPSM
);

  localparam int CW = (DT_BITS > BITS_DATA) ? DT_BITS : BITS_DATA;
  localparam logic [BITS_DATA-1:0] P_MIN = BITS_DATA'(4);
  localparam logic [BITS_DATA-1:0] H_RST = BITS_DATA'(2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_STOP} state_t;

  state_t                      state_q, state_d;
  logic                        rdy_q;
  logic [BITS_DATA-1:0]        cnt_q, cnt_d;
  logic                        pend_q, pend_d;
  logic                        ack_q, sync_q, run_q;

  logic [BITS_DATA-1:0]        sh_per_q;
  logic [N_LEGS*BITS_DATA-1:0] sh_ph_q;
  logic [DT_BITS-1:0]          sh_dt_q;

  logic [BITS_DATA-1:0]        act_per_q;
  logic [N_LEGS*BITS_DATA-1:0] act_ph_q;
  logic [DT_BITS-1:0]          act_dt_q;
  logic [BITS_DATA-1:0]        act_half_q;

  logic                        wrap, activate, load_active;

  // Clamp path: START loads straight from the ports, a wrap loads from the shadow.
  logic [BITS_DATA-1:0]        src_per, cl_per, cl_half, half_m1;
  logic [N_LEGS*BITS_DATA-1:0] src_ph, cl_ph;
  logic [DT_BITS-1:0]          src_dt, cl_dt;
  logic [BITS_DATA:0]          per_p1;

  assign src_per = (state_q == S_START) ? iPERIOD   : sh_per_q;
  assign src_ph  = (state_q == S_START) ? iPHASE    : sh_ph_q;
  assign src_dt  = (state_q == S_START) ? iDEADTIME : sh_dt_q;

  assign cl_per  = (src_per < P_MIN) ? P_MIN : src_per;
  assign per_p1  = {1'b0, cl_per} + (BITS_DATA+1)'(1);
  assign cl_half = BITS_DATA'(per_p1 >> 1);
  assign half_m1 = cl_half - BITS_DATA'(1);
  // Deadtime must leave at least one active cycle in each half period.
  assign cl_dt   = (CW'(src_dt) > CW'(half_m1)) ? DT_BITS'(half_m1) : src_dt;

  generate
    for (genvar gi = 0; gi < N_LEGS; gi++) begin : g_clamp
      assign cl_ph[gi*BITS_DATA +: BITS_DATA] =
        (src_ph[gi*BITS_DATA +: BITS_DATA] > cl_per) ? cl_per
                                                     : src_ph[gi*BITS_DATA +: BITS_DATA];
    end
  endgenerate

  // cnt never exceeds the active top: the top only changes at cnt==0.
  assign wrap        = ((state_q == S_RUN) || (state_q == S_STOP)) && (cnt_q >= act_per_q);
  assign activate    = (state_q == S_RUN) && wrap && pend_q;
  assign load_active = (state_q == S_START) || activate;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iEN && rdy_q) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + BITS_DATA'(1);
        if (!iEN) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = wrap ? '0 : cnt_q + BITS_DATA'(1);
        if (wrap) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A load arriving on the wrap cycle re-arms pending for the following wrap.
  always_comb begin
    pend_d = pend_q;
    if (activate)             pend_d = 1'b0;
    if (iLOAD)                pend_d = 1'b1;
    if (state_q == S_START)   pend_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      sync_q     <= 1'b0;
      run_q      <= 1'b0;
      sh_per_q   <= P_MIN;
      sh_ph_q    <= '0;
      sh_dt_q    <= '0;
      act_per_q  <= P_MIN;
      act_ph_q   <= '0;
      act_dt_q   <= '0;
      act_half_q <= H_RST;
    end else begin
      // rdy_q delays the first START by one edge after reset release.
      rdy_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (iLOAD) begin
        sh_per_q <= iPERIOD;
        sh_ph_q  <= iPHASE;
        sh_dt_q  <= iDEADTIME;
      end
      if (load_active) begin
        act_per_q  <= cl_per;
        act_ph_q   <= cl_ph;
        act_dt_q   <= cl_dt;
        act_half_q <= cl_half;
      end
      ack_q  <= activate;
      run_q  <= (state_d != S_IDLE);
      sync_q <= (state_d == S_RUN) && (cnt_d == '0);
    end
  end

  assign oLOAD_ACK = ack_q;
  assign oSYNC     = sync_q;
  assign oRUN      = run_q;

  generate
    for (genvar gi = 0; gi < N_LEGS; gi++) begin : g_leg
      logic [BITS_DATA-1:0] ph;
      logic [BITS_DATA:0]   pos;
      logic                 ref_w, edge_w;
      logic                 r_q, r_d, rp_q;
      logic [DT_BITS-1:0]   dt_q, dt_d;
      logic [1:0]           out_q, out_d;

      assign ph  = act_ph_q[gi*BITS_DATA +: BITS_DATA];
      // One extra bit keeps cnt+P+1 from overflowing before the subtraction.
      assign pos = (cnt_q >= ph)
                 ? ({1'b0, cnt_q} - {1'b0, ph})
                 : ({1'b0, cnt_q} + {1'b0, act_per_q} + (BITS_DATA+1)'(1) - {1'b0, ph});
      assign ref_w  = (pos < {1'b0, act_half_q});
      assign edge_w = r_q ^ rp_q;

      // The reference is forced low outside RUN, so every run starts from a
      // known low reference.
      always_comb begin
        r_d   = (state_q == S_RUN) & ref_w;
        dt_d  = dt_q;
        out_d = 2'b00;
        if (state_d != S_RUN) begin
          dt_d = '0;
        end else if (edge_w) begin
          if (act_dt_q == '0) begin
            out_d = {~r_q, r_q};
            dt_d  = '0;
          end else begin
            dt_d  = act_dt_q - DT_BITS'(1);
          end
        end else if (dt_q != '0) begin
          dt_d = dt_q - DT_BITS'(1);
        end else begin
          out_d = {~r_q, r_q};
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_q   <= 1'b0;
          rp_q  <= 1'b0;
          dt_q  <= '0;
          out_q <= 2'b00;
        end else begin
          r_q   <= r_d;
          rp_q  <= r_q;
          dt_q  <= dt_d;
          out_q <= out_d;
        end
      end

      assign oPSM[2*gi +: 2] = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_psm_phase_gen.sv
// Directed testbench for psm_phase_gen (BITS_DATA=16, N_LEGS=4, DT_BITS=8).
module tb_psm_phase_gen;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iEN;
  logic [15:0] iPERIOD;
  logic [63:0] iPHASE;
  logic [7:0]  iDEADTIME;
  logic        iLOAD;
  logic        oLOAD_ACK;
  logic        oSYNC;
  logic        oRUN;
  logic [7:0]  oPSM;

  localparam logic [7:0] EVEN = 8'h55;

  int n_pass = 0;
  int n_total = 0;

  // Expected behaviour: active values, shadow values, counter position.
  int p_m, d_m, sp_m, sd_m, cnt_m;
  int ph_m[4];
  int sph_m[4];
  bit pend_m, ack_m;

  psm_phase_gen #(.BITS_DATA(16), .N_LEGS(4), .DT_BITS(8)) dut (
    .CLK(CLK), .nRST(nRST), .iEN(iEN), .iPERIOD(iPERIOD), .iPHASE(iPHASE),
    .iDEADTIME(iDEADTIME), .iLOAD(iLOAD), .oLOAD_ACK(oLOAD_ACK), .oSYNC(oSYNC),
    .oRUN(oRUN), .oPSM(oPSM)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cnt %0d)", tag, obs, exp_v, cnt_m);
  endtask

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Steady-state gate pair for one leg at counter value c. u is the output-time
  // position after the rising reference edge (2 cycles of pipeline latency).
  function automatic logic [1:0] exp_leg(int c, int p, int ph, int d);
    int h, m, u;
    h = (p + 1) / 2;
    m = c - ph - 2;
    while (m < 0) m += p + 1;
    m = m % (p + 1);
    u = m + 2;
    if (u <= 1 + d)          return 2'b00;
    else if (u <= h + 1)     return 2'b01;
    else if (u <= h + 1 + d) return 2'b00;
    else                     return 2'b10;
  endfunction

  function automatic logic [7:0] model_psm();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = exp_leg(cnt_m, p_m, ph_m[i], d_m);
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    tick();
    ack_m = 1'b0;
    if (cnt_m >= p_m) begin
      cnt_m = 0;
      if (pend_m) begin
        p_m = sp_m; d_m = sd_m; ph_m = sph_m;
        pend_m = 1'b0;
        ack_m  = 1'b1;
      end
    end else begin
      cnt_m++;
    end
  endtask

  task automatic check_now(input bit chk);
    check("sync", 32'(oSYNC), 32'(cnt_m == 0));
    check("ack", 32'(oLOAD_ACK), 32'(ack_m));
    check("shoot", 32'(oPSM & (oPSM >> 1) & EVEN), 32'd0);
    if (chk) check("psm", 32'(oPSM), 32'(model_psm()));
  endtask

  task automatic run(input int n, input bit chk);
    for (int k = 0; k < n; k++) begin
      check_now(chk);
      cyc();
    end
  endtask

  task automatic set_in(input int p, input int a0, input int a1, input int a2,
                        input int a3, input int d);
    iPERIOD   = 16'(p);
    iPHASE    = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    iDEADTIME = 8'(d);
  endtask

  task automatic do_load(input bit chk, input int p, input int a0, input int a1,
                         input int a2, input int a3, input int d, input int ep,
                         input int e0, input int e1, input int e2, input int e3,
                         input int ed);
    set_in(p, a0, a1, a2, a3, d);
    iLOAD = 1'b1;
    check_now(chk);
    cyc();
    iLOAD = 1'b0;
    sp_m = ep; sd_m = ed; sph_m = '{e0, e1, e2, e3};
    pend_m = 1'b1;
  endtask

  task automatic begin_run();
    cnt_m = 0; ack_m = 1'b0; pend_m = 1'b0;
  endtask

  initial begin
    int g, rp, r0, r1, r2, r3, rd, cp, h;
    nRST = 1'b0; iEN = 1'b1; iLOAD = 1'b0;
    set_in(9, 0, 3, 5, 9, 1);
    p_m = 9; d_m = 1; ph_m = '{0, 3, 5, 9}; sph_m = ph_m; sp_m = 9; sd_m = 1;
    begin_run();

    // Reset state, before any clock edge
    #2;
    check("rst_psm", 32'(oPSM), 0);
    check("rst_sync", 32'(oSYNC), 0);
    check("rst_run", 32'(oRUN), 0);
    check("rst_ack", 32'(oLOAD_ACK), 0);
    tick(); tick();
    #4 nRST = 1'b1;
    tick();
    check("rel_edge1_run", 32'(oRUN), 0);
    tick();
    check("start_run", 32'(oRUN), 1);
    check("start_sync", 32'(oSYNC), 0);
    tick();
    begin_run();

    // Basic run: P=9, phases 0/3/5/9, D=1
    run(10, 0);
    run(10, 1);

    // Port changes without iLOAD are ignored
    set_in(6, 1, 2, 4, 6, 3);
    run(10, 1);
    run(10, 1);

    // Deferred load at cnt=4: leg1 phase 3 -> 6
    run(4, 1);
    do_load(1, 9, 0, 6, 5, 9, 1, 9, 0, 6, 5, 9, 1);
    run(5, 1);
    run(10, 0);
    run(10, 1);

    // Load on the wrap cycle activates one period later
    run(9, 1);
    do_load(1, 9, 0, 3, 5, 9, 2, 9, 0, 3, 5, 9, 2);
    run(10, 1);
    run(10, 0);
    run(10, 1);

    // Clamps: phase0=20 -> 9, D=10 -> 4
    do_load(1, 9, 20, 3, 5, 9, 10, 9, 9, 3, 5, 9, 4);
    run(9, 1);
    run(10, 0);
    run(10, 1);

    // Clamps: P=2 -> 4, phase3=9 -> 4, D=10 -> 1
    do_load(1, 2, 0, 1, 3, 9, 10, 4, 0, 1, 3, 4, 1);
    run(9, 1);
    run(5, 0);
    run(5, 1);
    run(5, 1);

    // Random sweep of loads; shoot-through, sync and ack checked every cycle
    for (int k = 0; k < 30; k++) begin
      rp = $urandom_range(0, 20);
      r0 = $urandom_range(0, 25); r1 = $urandom_range(0, 25);
      r2 = $urandom_range(0, 25); r3 = $urandom_range(0, 25);
      rd = $urandom_range(0, 15);
      cp = (rp < 4) ? 4 : rp;
      h  = (cp + 1) / 2;
      do_load(0, rp, r0, r1, r2, r3, rd, cp, mn(r0, cp), mn(r1, cp), mn(r2, cp),
              mn(r3, cp), mn(rd, h - 1));
      run($urandom_range(0, 12), 0);
    end

    // Back to a known pattern
    do_load(0, 9, 0, 3, 5, 9, 1, 9, 0, 3, 5, 9, 1);
    g = 0;
    while (pend_m && g < 60) begin
      run(1, 0);
      g++;
    end
    run(p_m + 1, 0);
    run(10, 1);

    // Stop sequence: iEN dropped at cnt=3, re-raised during STOP
    g = 0;
    while (cnt_m != 3 && g < 20) begin
      run(1, 1);
      g++;
    end
    iEN = 1'b0;
    check_now(1);
    cyc();
    for (int k = 4; k <= 9; k++) begin
      check("stop_psm", 32'(oPSM), 0);
      check("stop_run", 32'(oRUN), 1);
      check("stop_sync", 32'(oSYNC), 0);
      if (k == 6) iEN = 1'b1;
      cyc();
    end
    check("idle_run", 32'(oRUN), 0);
    check("idle_psm", 32'(oPSM), 0);
    tick();
    check("restart_run", 32'(oRUN), 1);
    check("restart_sync", 32'(oSYNC), 0);
    tick();
    begin_run();
    run(10, 0);
    run(10, 1);

    // Asynchronous reset mid-period
    run(3, 1);
    #3 nRST = 1'b0;
    #1;
    check("arst_psm", 32'(oPSM), 0);
    check("arst_sync", 32'(oSYNC), 0);
    check("arst_run", 32'(oRUN), 0);
    check("arst_ack", 32'(oLOAD_ACK), 0);
    tick();
    check("arst_hold_run", 32'(oRUN), 0);
    #4 nRST = 1'b1;
    tick();
    check("arst_rel1_run", 32'(oRUN), 0);
    tick();
    check("arst_start_run", 32'(oRUN), 1);
    tick();
    begin_run();
    run(10, 0);
    run(10, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
